uart_rx_fifo: RTL and testbench

UART_RX_FIFO -- requirements
Module: uart_rx_fifo

---
 rtl/uart_pkg.sv | 11 +
 rtl/sync_fifo_core.sv | 84 ++++++++
 rtl/uart_rx_fifo.sv | 113 +++++++++++
 tb/tb_uart_rx_fifo.sv | 149 ++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: shared constants for the UART receive FIFO slice.
//   UART_DATA_W        - byte width carried through the FIFO
//   UART_RX_DEPTH      - default FIFO depth (power of two, 4..256)
//   UART_RX_THRESH     - default fill level at/above which irq asserts
//   UART_RX_TIMEOUT_CYC- default idle cycles before the timeout flag sets
package uart_pkg;
  localparam int UART_DATA_W         = 8;
  localparam int UART_RX_DEPTH       = 16;
  localparam int UART_RX_THRESH      = 8;
  localparam int UART_RX_TIMEOUT_CYC = 4096;
endpackage

// File: rtl/sync_fifo_core.sv
// sync_fifo_core: storage, pointers and fill count for the UART RX FIFO.
// Show-ahead: rd_data_o is a register that always holds the oldest entry
// while the FIFO is non-empty; it updates on the same edge as count_o.
// Ports:
//   clk_i, rst_i        - clock, synchronous active-high reset
//   wr_valid_i/wr_data_i- write strobe and byte
//   rd_req_i            - pop request (ignored while empty)
//   rd_data_o           - head entry (held, stable while empty)
//   count_o/count_next_o- current and next-edge fill level
//   empty_o/full_o      - derived from count
//   push_o/pop_o        - qualified push/pop this cycle
// Strobe semantics: there is no back-pressure. A write is accepted when not
// full, or when full with a same-cycle pop; a pop is accepted when not empty.
module sync_fifo_core
  import uart_pkg::*;
#(
  parameter int DEPTH = UART_RX_DEPTH,
  parameter int W     = UART_DATA_W
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       wr_valid_i,
  input  logic [W-1:0]               wr_data_i,
  input  logic                       rd_req_i,
  output logic [W-1:0]               rd_data_o,
  output logic [$clog2(DEPTH):0]     count_o,
  output logic [$clog2(DEPTH):0]     count_next_o,
  output logic                       empty_o,
  output logic                       full_o,
  output logic                       push_o,
  output logic                       pop_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q, rd_ptr_nx;
  logic [CW-1:0] count_q, count_d;
  logic [W-1:0]  rd_data_q, rd_data_d;
  logic          push, pop, empty, full;

  assign empty     = (count_q == '0);
  assign full      = (count_q == CW'(DEPTH));
  assign push      = wr_valid_i && (!full || rd_req_i);
  assign pop       = rd_req_i && !empty;
  // Pointers are AW bits wide so they wrap modulo DEPTH on their own.
  assign rd_ptr_nx = rd_ptr_q + 1'b1;

  always_comb begin
    count_d   = count_q;
    rd_data_d = rd_data_q;
    if (push && !pop)      count_d = count_q + 1'b1;
    else if (pop && !push) count_d = count_q - 1'b1;
    // The incoming byte becomes the head when the FIFO is empty, or when the
    // only stored byte is popped in the same cycle.
    if (push && (empty || (pop && count_q == CW'(1)))) rd_data_d = wr_data_i;
    else if (pop && count_q > CW'(1))                  rd_data_d = mem_q[rd_ptr_nx];
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      rd_data_q <= '0;
    end else begin
      if (push) begin
        mem_q[wr_ptr_q] <= wr_data_i;
        wr_ptr_q        <= wr_ptr_q + 1'b1;
      end
      if (pop) rd_ptr_q <= rd_ptr_nx;
      count_q   <= count_d;
      rd_data_q <= rd_data_d;
    end
  end

  assign rd_data_o    = rd_data_q;
  assign count_o      = count_q;
  assign count_next_o = count_d;
  assign empty_o      = empty;
  assign full_o       = full;
  assign push_o       = push;
  assign pop_o        = pop;
endmodule

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: UART receive FIFO with sticky overflow and level interrupt.
// Optional idle timeout counter is compiled in with `define UART_RX_TIMEOUT_EN.
// Ports:
//   clk, RST            - clock, synchronous active-high reset
//   rx_data/rx_valid    - byte and one-cycle strobe from the UART receiver
//   rd_en               - pop strobe from the bus interface
//   ovf_clr             - clears the sticky overflow flag
//   rd_data             - head entry, show-ahead
//   empty/full/count    - fill status, valid one edge after the strobe
//   overflow            - sticky: a byte was dropped while full
//   irq                 - registered level interrupt (threshold or timeout)
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH       = UART_RX_DEPTH,
  parameter int THRESH      = UART_RX_THRESH,
  parameter int TIMEOUT_CYC = UART_RX_TIMEOUT_CYC
) (
  input  logic                   clk,
  input  logic                   RST,
  input  logic [UART_DATA_W-1:0] rx_data,
  input  logic                   rx_valid,
  input  logic                   rd_en,
  input  logic                   ovf_clr,
  output logic [UART_DATA_W-1:0] rd_data,
  output logic                   empty,
  output logic                   full,
  output logic [$clog2(DEPTH):0] count,
  output logic                   overflow,
  output logic                   irq
);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] THRESH_C = CW'(THRESH);

  logic [CW-1:0] count_next;
  logic          push, pop;
  logic          ovf_q, ovf_d;
  logic          irq_q, irq_d;
  logic          to_flag_d;

  sync_fifo_core #(.DEPTH(DEPTH), .W(UART_DATA_W)) u_core (
    .clk_i        (clk),
    .rst_i        (RST),
    .wr_valid_i   (rx_valid),
    .wr_data_i    (rx_data),
    .rd_req_i     (rd_en),
    .rd_data_o    (rd_data),
    .count_o      (count),
    .count_next_o (count_next),
    .empty_o      (empty),
    .full_o       (full),
    .push_o       (push),
    .pop_o        (pop)
  );

`ifdef UART_RX_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC) + 1;
  logic [TW-1:0] to_cnt_q, to_cnt_d;
  logic          to_flag_q;

  // Counter runs only while data sits untouched; it saturates once the
  // flag sets and both clear on any FIFO activity or when drained.
  always_comb begin
    to_cnt_d  = to_cnt_q;
    to_flag_d = to_flag_q;
    if (push || pop || empty) begin
      to_cnt_d  = '0;
      to_flag_d = 1'b0;
    end else if (to_cnt_q == TW'(TIMEOUT_CYC - 1)) begin
      to_flag_d = 1'b1;
    end else begin
      to_cnt_d = to_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (RST) begin
      to_cnt_q  <= '0;
      to_flag_q <= 1'b0;
    end else begin
      to_cnt_q  <= to_cnt_d;
      to_flag_q <= to_flag_d;
    end
  end
`else
  // No timeout in this build; the comparison is constant false for any
  // legal TIMEOUT_CYC and only keeps the parameter referenced.
  assign to_flag_d = (TIMEOUT_CYC < 0);
`endif

  always_comb begin
    ovf_d = ovf_q;
    // A byte dropped this cycle outranks a same-cycle clear.
    if (rx_valid && full && !rd_en) ovf_d = 1'b1;
    else if (ovf_clr)               ovf_d = 1'b0;
    // irq is built from next-state values so it changes on the same edge
    // as count.
    irq_d = (count_next >= THRESH_C) || to_flag_d;
  end

  always_ff @(posedge clk) begin
    if (RST) begin
      ovf_q <= 1'b0;
      irq_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
      irq_q <= irq_d;
    end
  end

  assign overflow = ovf_q;
  assign irq      = irq_q;
endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb_uart_rx_fifo: directed self-checking bench for uart_rx_fifo
// (DEPTH=16, THRESH=8, TIMEOUT_CYC=32). Honors `UART_RX_TIMEOUT_EN.
module tb_uart_rx_fifo;
  logic       clk = 1'b0;
  logic       RST;
  logic [7:0] rx_data;
  logic       rx_valid, rd_en, ovf_clr;
  logic [7:0] rd_data;
  logic       empty, full, overflow, irq;
  logic [4:0] count;

  int n_checks = 0;
  int n_errors = 0;
  logic [7:0] exp_q[$];

  uart_rx_fifo #(.DEPTH(16), .THRESH(8), .TIMEOUT_CYC(32)) dut (
    .clk(clk), .RST(RST), .rx_data(rx_data), .rx_valid(rx_valid),
    .rd_en(rd_en), .ovf_clr(ovf_clr), .rd_data(rd_data), .empty(empty),
    .full(full), .count(count), .overflow(overflow), .irq(irq)
  );

  // clock/reset block
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // driver: apply strobes for one clock, sample 1 time unit after the edge
  task automatic step(input logic rst, input logic rxv, input logic [7:0] d,
                      input logic rd, input logic clr);
    RST = rst; rx_valid = rxv; rx_data = d; rd_en = rd; ovf_clr = clr;
    @(posedge clk); #1;
    RST = 1'b0; rx_valid = 1'b0; rx_data = 8'h00; rd_en = 1'b0; ovf_clr = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
  endtask

  initial begin
    RST = 1'b1; rx_valid = 1'b0; rx_data = 8'h00; rd_en = 1'b0; ovf_clr = 1'b0;
    // reset with strobes active: strobes must be ignored
    step(1'b1, 1'b1, 8'h77, 1'b1, 1'b0);
    step(1'b1, 1'b1, 8'h77, 1'b0, 1'b0);
    chk("rst_count", count, 0);
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_irq", irq, 0);
    chk("rst_rd_data", rd_data, 8'h00);

    // single push / pop
    step(1'b0, 1'b1, 8'hA5, 1'b0, 1'b0);
    chk("a5_empty", empty, 0);
    chk("a5_count", count, 1);
    chk("a5_rd_data", rd_data, 8'hA5);
    step(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    chk("a5_pop_empty", empty, 1);
    chk("a5_pop_count", count, 0);

    // fill with 00..0F, irq at threshold 8
    for (int i = 0; i < 16; i++) begin
      step(1'b0, 1'b1, 8'(i), 1'b0, 1'b0);
      exp_q.push_back(8'(i));
      if (i == 6) chk("fill_irq_below", irq, 0);
      if (i == 7) chk("fill_irq_at8", irq, 1);
    end
    chk("fill_full", full, 1);
    chk("fill_count", count, 16);
    chk("fill_irq", irq, 1);
    chk("fill_head", rd_data, 8'h00);

    // overflow while full
    step(1'b0, 1'b1, 8'hFF, 1'b0, 1'b0);
    chk("ovf_set", overflow, 1);
    chk("ovf_count", count, 16);
    chk("ovf_head", rd_data, 8'h00);
    step(1'b0, 1'b1, 8'hFF, 1'b0, 1'b1);
    chk("ovf_clr_vs_event", overflow, 1);
    step(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
    chk("ovf_cleared", overflow, 0);

    // push + pop while full
    step(1'b0, 1'b1, 8'h55, 1'b1, 1'b0);
    void'(exp_q.pop_front());
    exp_q.push_back(8'h55);
    chk("fullrw_count", count, 16);
    chk("fullrw_ovf", overflow, 0);
    chk("fullrw_head", rd_data, 8'h01);

    // drain: expect 01..0F then 55
    while (exp_q.size() > 0) begin
      chk("drain_head", rd_data, exp_q[0]);
      step(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
      void'(exp_q.pop_front());
      chk("drain_count", count, 32'(exp_q.size()));
      chk("drain_irq", irq, (exp_q.size() >= 8) ? 1 : 0);
    end
    chk("drain_empty", empty, 1);
    chk("drain_irq_end", irq, 0);

    // push + pop on empty: push only
    step(1'b0, 1'b1, 8'h3C, 1'b1, 1'b0);
    chk("emptyrw_count", count, 1);
    chk("emptyrw_head", rd_data, 8'h3C);
    step(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    chk("pop3c_empty", empty, 1);
    step(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    chk("pop_empty_count", count, 0);
    chk("pop_empty_empty", empty, 1);
    chk("pop_empty_ovf", overflow, 0);

    // idle timeout
    step(1'b0, 1'b1, 8'h11, 1'b0, 1'b0);
    idle(31);
    chk("to_before", irq, 0);
    idle(1);
`ifdef UART_RX_TIMEOUT_EN
    chk("to_irq", irq, 1);
`else
    chk("to_irq_off", irq, 0);
`endif
    chk("to_head", rd_data, 8'h11);
    step(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    chk("to_pop_irq", irq, 0);
    chk("to_pop_empty", empty, 1);

    // reset mid-operation discards data
    step(1'b0, 1'b1, 8'h21, 1'b0, 1'b0);
    step(1'b0, 1'b1, 8'h22, 1'b0, 1'b0);
    step(1'b0, 1'b1, 8'h23, 1'b0, 1'b0);
    chk("pre_rst_count", count, 3);
    step(1'b1, 1'b1, 8'h99, 1'b0, 1'b0);
    chk("mid_rst_count", count, 0);
    chk("mid_rst_empty", empty, 1);
    chk("mid_rst_rd_data", rd_data, 8'h00);
    step(1'b0, 1'b1, 8'h9A, 1'b0, 1'b0);
    chk("post_rst_count", count, 1);
    chk("post_rst_head", rd_data, 8'h9A);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
